// File: rtl/mips_mem_pkg.sv
// Shared definitions for the mips memory subsystem: the port handshake
// state encoding, wait-counter width and the default error read pattern.
package mips_mem_pkg;

    // Handshake states of one memory port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } port_state_t;

    // Wait-state counter width; supports 0..15 wait states.
    localparam int WAIT_CNT_W = 4;

    // Value returned by an out-of-range data read unless overridden.
    localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_mem_sys_mem_port_ctrl.sv
// Request/acknowledge controller for one memory port: latches the request,
// counts wait states and produces a single-cycle "fire" strobe on the edge
// where the array access happens, followed by a registered one-cycle ACK.
module mem_port_ctrl
    import mips_mem_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int BEW      = DW / 8,
    parameter int WAIT_CYC = 0,
    parameter bit WR_EN    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [AW-1:0]  addr,
    input  logic           we,
    input  logic [BEW-1:0] be,
    input  logic [DW-1:0]  wdata,
    output logic           fire,
    output logic [AW-1:0]  fire_addr,
    output logic           fire_we,
    output logic [BEW-1:0] fire_be,
    output logic [DW-1:0]  fire_wdata,
    output logic           ack
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYC);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    port_state_t           state_reg, state_next;
    logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;
    logic [AW-1:0]         addr_reg;
    logic                  we_reg;
    logic [BEW-1:0]        be_reg;
    logic [DW-1:0]         wdata_reg;
    logic                  take;
    logic                  fire_raw;
    logic                  use_latched;

    // State, wait counter, request latch and registered ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
            ack       <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack       <= fire;
            if (take) begin
                addr_reg  <= addr;
                we_reg    <= we;
                be_reg    <= be;
                wdata_reg <= wdata;
            end
        end
    end

    // Next-state logic: a request is accepted in IDLE and in the ACK cycle,
    // so zero-wait ports can complete one access per cycle.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        take        = 1'b0;
        fire_raw    = 1'b0;
        use_latched = 1'b0;
        case (state_reg)
            ST_IDLE, ST_ACK: begin
                state_next = ST_IDLE;
                if (req) begin
                    take = 1'b1;
                    if (WAIT_CYC > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = ST_ACK;
                        fire_raw   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg <= CNT_ONE) begin
                    state_next  = ST_ACK;
                    fire_raw    = 1'b1;
                    use_latched = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Access fields seen by the arrays: live inputs for a zero-wait access,
    // the latched copy once wait states have elapsed. Fire is suppressed
    // while reset is held so no write can slip in during reset.
    always_comb begin
        fire       = fire_raw & ~rst;
        fire_addr  = use_latched ? addr_reg : addr;
        fire_we    = WR_EN & (use_latched ? we_reg : we);
        fire_be    = use_latched ? be_reg : be;
        fire_wdata = use_latched ? wdata_reg : wdata;
    end

endmodule

// File: rtl/mips_mem_sys.sv
module mips_mem_sys
    import mips_mem_pkg::*;
#(
    parameter int            DW         = 32,
    parameter int            AW         = 32,
    parameter int            IM_DEPTH_W = 10,
    parameter int            DM_DEPTH_W = 10,
    parameter int            IM_WAIT    = 0,
    parameter int            DM_WAIT    = 1,
    parameter logic [AW-1:0] DM_LIMIT   = AW'(32'h0000_00FF),
    parameter logic [DW-1:0] ERR_DATA   = DW'(ERR_DATA_DEF),
    parameter string         IM_INIT    = "",
    parameter string         DM_INIT    = ""
) (
    input  logic            CLK,
    input  logic            Z_R,
    input  logic            IM_REQ,
    input  logic [AW-1:0]   IM_ADDR,
    output logic            IM_ACK,
    output logic [DW-1:0]   IM_DATA,
    input  logic            DM_REQ,
    input  logic            DM_WE,
    input  logic [DW/8-1:0] DM_BE,
    input  logic [AW-1:0]   DM_ADDR,
    input  logic [DW-1:0]   DM_WR_DATA,
    output logic            DM_ACK,
    output logic [DW-1:0]   DM_RD_DATA,
    output logic            DM_ERR
);

    localparam int BEW      = DW / 8;
    localparam int IM_WORDS = 1 << IM_DEPTH_W;
    localparam int DM_WORDS = 1 << DM_DEPTH_W;

    logic [DW-1:0] im_mem [IM_WORDS];
    logic [DW-1:0] dm_mem [DM_WORDS];

    logic                  im_fire, dm_fire;
    logic [AW-1:0]         im_fire_addr, dm_fire_addr;
    logic                  im_fire_we, dm_fire_we;
    logic [BEW-1:0]        im_fire_be, dm_fire_be;
    logic [DW-1:0]         im_fire_wdata, dm_fire_wdata;
    logic [IM_DEPTH_W-1:0] im_idx;
    logic [DM_DEPTH_W-1:0] dm_idx;
    logic                  dm_oor;
    logic                  dm_commit;
    logic                  im_unused;

    mem_port_ctrl #(
        .AW(AW), .DW(DW), .BEW(BEW), .WAIT_CYC(IM_WAIT), .WR_EN(1'b0)
    ) u_im_ctrl (
        .clk        (CLK),
        .rst        (Z_R),
        .req        (IM_REQ),
        .addr       (IM_ADDR),
        .we         (1'b0),
        .be         ({BEW{1'b0}}),
        .wdata      ({DW{1'b0}}),
        .fire       (im_fire),
        .fire_addr  (im_fire_addr),
        .fire_we    (im_fire_we),
        .fire_be    (im_fire_be),
        .fire_wdata (im_fire_wdata),
        .ack        (IM_ACK)
    );

    mem_port_ctrl #(
        .AW(AW), .DW(DW), .BEW(BEW), .WAIT_CYC(DM_WAIT), .WR_EN(1'b1)
    ) u_dm_ctrl (
        .clk        (CLK),
        .rst        (Z_R),
        .req        (DM_REQ),
        .addr       (DM_ADDR),
        .we         (DM_WE),
        .be         (DM_BE),
        .wdata      (DM_WR_DATA),
        .fire       (dm_fire),
        .fire_addr  (dm_fire_addr),
        .fire_we    (dm_fire_we),
        .fire_be    (dm_fire_be),
        .fire_wdata (dm_fire_wdata),
        .ack        (DM_ACK)
    );

    always_comb begin
        im_idx    = im_fire_addr[IM_DEPTH_W+1:2];
        dm_idx    = dm_fire_addr[DM_DEPTH_W+1:2];
        dm_oor    = dm_fire_addr > DM_LIMIT;
        dm_commit = dm_fire & dm_fire_we & ~dm_oor;
        im_unused = ^{im_fire_we, im_fire_be, im_fire_wdata,
                      im_fire_addr[1:0], im_fire_addr[AW-1:IM_DEPTH_W+2]};
    end

    always_ff @(posedge CLK or posedge Z_R) begin
        if (Z_R) begin
            IM_DATA <= '0;
        end else if (im_fire) begin
            IM_DATA <= im_mem[im_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (dm_commit) begin
            for (int i = 0; i < BEW; i++) begin
                if (dm_fire_be[i]) begin
                    dm_mem[dm_idx][i*8 +: 8] <= dm_fire_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Z_R) begin
        if (Z_R) begin
            DM_RD_DATA <= '0;
            DM_ERR     <= 1'b0;
        end else begin
            DM_ERR <= dm_fire & dm_oor;
            if (dm_fire && !dm_fire_we) begin
                DM_RD_DATA <= dm_oor ? ERR_DATA : dm_mem[dm_idx];
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_sys.sv
// Self-checking bench for mips_mem_sys: randomized traffic on both ports
// checked against plain array models of the instruction and data memories.
module tb_mips_mem_sys;

    localparam int          DM_DEPTH_W = 6;
    localparam int          DM_WORDS   = 1 << DM_DEPTH_W;
    localparam int          IM_WORDS   = 1024;
    localparam int          DMW        = 2;
    localparam logic [31:0] LIMIT      = 32'h0000_00FF;

    logic        CLK = 1'b0;
    logic        Z_R = 1'b0;
    logic        IM_REQ = 1'b0;
    logic [31:0] IM_ADDR = '0;
    logic        IM_ACK;
    logic [31:0] IM_DATA;
    logic        DM_REQ = 1'b0;
    logic        DM_WE = 1'b0;
    logic [3:0]  DM_BE = '0;
    logic [31:0] DM_ADDR = '0;
    logic [31:0] DM_WR_DATA = '0;
    logic        DM_ACK;
    logic [31:0] DM_RD_DATA;
    logic        DM_ERR;

    int checks = 0;
    int errors = 0;

    logic [31:0] im_model [IM_WORDS];
    logic [31:0] dm_model [DM_WORDS];
    logic [31:0] last_rd;

    mips_mem_sys #(
        .DW(32), .AW(32), .IM_DEPTH_W(10), .DM_DEPTH_W(DM_DEPTH_W),
        .IM_WAIT(0), .DM_WAIT(DMW), .DM_LIMIT(LIMIT), .ERR_DATA(32'hFFFF_FFFF),
        .IM_INIT(""), .DM_INIT("")
    ) dut (
        .CLK(CLK), .Z_R(Z_R),
        .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_ACK(IM_ACK), .IM_DATA(IM_DATA),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_BE(DM_BE), .DM_ADDR(DM_ADDR),
        .DM_WR_DATA(DM_WR_DATA), .DM_ACK(DM_ACK), .DM_RD_DATA(DM_RD_DATA),
        .DM_ERR(DM_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Reference model of one data access: what the memory should hold and
    // what the port should report afterwards.
    task automatic model_dm(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] exp_rd,
                            output logic exp_err);
        int idx;
        idx     = int'((addr >> 2) % DM_WORDS);
        exp_err = (addr > LIMIT);
        if (we) begin
            if (!exp_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) dm_model[idx][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
            exp_rd = last_rd;
        end else begin
            exp_rd  = exp_err ? 32'hFFFF_FFFF : dm_model[idx];
            last_rd = exp_rd;
        end
    endtask

    // Drives one data access and reports what came back; lat = -1 on timeout.
    task automatic dm_do(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rd, output logic err);
        DM_REQ = 1'b1; DM_WE = we; DM_BE = be; DM_ADDR = addr; DM_WR_DATA = wdata;
        tick;
        lat = 1;
        DM_REQ = 1'b0; DM_WE = ~we; DM_BE = ~be; DM_ADDR = $urandom; DM_WR_DATA = $urandom;
        while (!DM_ACK && lat < 40) begin
            tick;
            lat++;
        end
        if (!DM_ACK) lat = -1;
        rd  = DM_RD_DATA;
        err = DM_ERR;
    endtask

    task automatic test_reset;
        Z_R = 1'b1;
        repeat (2) tick;
        checks += 6;
        if (IM_ACK !== 1'b0) begin errors++; $display("FAIL reset_im_ack got %0b want 0", IM_ACK); end
        if (IM_DATA !== 32'h0) begin errors++; $display("FAIL reset_im_data got %h want 0", IM_DATA); end
        if (DM_ACK !== 1'b0) begin errors++; $display("FAIL reset_dm_ack got %0b want 0", DM_ACK); end
        if (DM_RD_DATA !== 32'h0) begin errors++; $display("FAIL reset_dm_rd got %h want 0", DM_RD_DATA); end
        if (DM_ERR !== 1'b0) begin errors++; $display("FAIL reset_dm_err got %0b want 0", DM_ERR); end
        if (dut.u_dm_ctrl.ack !== 1'b0) begin errors++; $display("FAIL reset_dm_ctrl_ack got %0b want 0", dut.u_dm_ctrl.ack); end
        Z_R = 1'b0;
        last_rd = 32'h0;
        tick;
        $display("reset: outputs cleared");
    endtask

    task automatic test_im_basic;
        logic [31:0] a;
        int idx;
        IM_REQ = 1'b1; IM_ADDR = 32'h8;
        tick;
        IM_REQ = 1'b0; IM_ADDR = $urandom;
        checks += 2;
        if (IM_ACK !== 1'b1) begin errors++; $display("FAIL im_latency ack got %0b want 1", IM_ACK); end
        if (IM_DATA !== 32'h2008_000A) begin errors++; $display("FAIL im_word2 got %h want 2008000a", IM_DATA); end
        tick;
        checks++;
        if (IM_ACK !== 1'b0) begin errors++; $display("FAIL im_ack_pulse got %0b want 0", IM_ACK); end
        IM_REQ = 1'b1; IM_ADDR = 32'h1008;
        tick;
        IM_REQ = 1'b0;
        checks++;
        if (IM_ACK !== 1'b1 || IM_DATA !== 32'h2008_000A) begin
            errors++; $display("FAIL im_wrap ack %0b data %h want 1 2008000a", IM_ACK, IM_DATA);
        end
        $display("im: addr 0x8 and 0x1008 -> %h", IM_DATA);
        tick;
        for (int n = 0; n < 10; n++) begin
            a = $urandom;
            idx = int'((a >> 2) % IM_WORDS);
            IM_REQ = 1'b1; IM_ADDR = a;
            tick;
            IM_REQ = 1'b0;
            checks++;
            if (IM_ACK !== 1'b1 || IM_DATA !== im_model[idx]) begin
                errors++; $display("FAIL im_rand addr %h ack %0b data %h want 1 %h", a, IM_ACK, IM_DATA, im_model[idx]);
            end
            $display("im: read %h -> %h", a, IM_DATA);
            tick;
        end
    endtask

    task automatic test_dm_preload;
        int lat; logic [31:0] rd, exp_rd; logic err, exp_err; logic [31:0] d;
        for (int w = 0; w < DM_WORDS; w++) begin
            d = $urandom;
            model_dm(1'b1, 4'hF, 32'(w * 4), d, exp_rd, exp_err);
            dm_do(1'b1, 4'hF, 32'(w * 4), d, lat, rd, err);
            checks++;
            if (lat !== DMW + 1 || err !== exp_err || rd !== exp_rd) begin
                errors++; $display("FAIL dm_preload word %0d lat %0d err %0b rd %h want %0d %0b %h", w, lat, err, rd, DMW + 1, exp_err, exp_rd);
            end
        end
        $display("dm: preloaded %0d words", DM_WORDS);
    endtask

    task automatic test_dm_basic;
        int lat; logic [31:0] rd, exp_rd; logic err, exp_err;
        model_dm(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, exp_rd, exp_err);
        dm_do(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, lat, rd, err);
        checks++;
        if (lat !== 3 || err !== 1'b0) begin errors++; $display("FAIL dm_write_lat lat %0d err %0b want 3 0", lat, err); end
        $display("dm: write 10 <- deadbeef lat %0d", lat);
        model_dm(1'b0, 4'h0, 32'h10, 32'h0, exp_rd, exp_err);
        dm_do(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, err);
        checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL dm_read_back lat %0d err %0b rd %h want 3 0 deadbeef", lat, err, rd);
        end
        $display("dm: read 10 -> %h lat %0d", rd, lat);
        tick;
        checks++;
        if (DM_ACK !== 1'b0 || DM_ERR !== 1'b0) begin
            errors++; $display("FAIL dm_ack_pulse ack %0b err %0b want 0 0", DM_ACK, DM_ERR);
        end
    endtask

    task automatic test_dm_byte_en;
        int lat; logic [31:0] rd, exp_rd; logic err, exp_err;
        model_dm(1'b1, 4'b0001, 32'h10, 32'h0000_00AA, exp_rd, exp_err);
        dm_do(1'b1, 4'b0001, 32'h10, 32'h0000_00AA, lat, rd, err);
        checks++;
        if (rd !== exp_rd) begin errors++; $display("FAIL dm_wr_hold rd %h want %h", rd, exp_rd); end
        model_dm(1'b0, 4'h0, 32'h10, 32'h0, exp_rd, exp_err);
        dm_do(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, err);
        checks++;
        if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL dm_be_merge rd %h want deadbeaa", rd); end
        $display("dm: byte write -> %h", rd);
        model_dm(1'b1, 4'b0000, 32'h12, 32'h5555_5555, exp_rd, exp_err);
        dm_do(1'b1, 4'b0000, 32'h12, 32'h5555_5555, lat, rd, err);
        checks++;
        if (lat !== 3 || err !== 1'b0) begin errors++; $display("FAIL dm_be0_ack lat %0d err %0b want 3 0", lat, err); end
        model_dm(1'b0, 4'h0, 32'h13, 32'h0, exp_rd, exp_err);
        dm_do(1'b0, 4'h0, 32'h13, 32'h0, lat, rd, err);
        checks++;
        if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL dm_be0_nochange rd %h want deadbeaa", rd); end
        $display("dm: be=0 write, read -> %h", rd);
    endtask

    task automatic test_dm_range;
        int lat; logic [31:0] rd, exp_rd, orig; logic err, exp_err;
        model_dm(1'b0, 4'h0, 32'h100, 32'h0, exp_rd, exp_err);
        dm_do(1'b0, 4'h0, 32'h100, 32'h0, lat, rd, err);
        checks++;
        if (lat !== 3 || err !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL dm_oor_read lat %0d err %0b rd %h want 3 1 ffffffff", lat, err, rd);
        end
        $display("dm: read 100 -> %h err %0b", rd, err);
        orig = dm_model[0];
        model_dm(1'b1, 4'hF, 32'h100, 32'h1234_5678, exp_rd, exp_err);
        dm_do(1'b1, 4'hF, 32'h100, 32'h1234_5678, lat, rd, err);
        checks++;
        if (lat !== 3 || err !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL dm_oor_write lat %0d err %0b rd %h want 3 1 ffffffff", lat, err, rd);
        end
        model_dm(1'b0, 4'h0, 32'h0, 32'h0, exp_rd, exp_err);
        dm_do(1'b0, 4'h0, 32'h0, 32'h0, lat, rd, err);
        checks++;
        if (err !== 1'b0 || rd !== orig) begin
            errors++; $display("FAIL dm_oor_discard err %0b rd %h want 0 %h", err, rd, orig);
        end
        $display("dm: alias read 0 -> %h", rd);
    endtask

    task automatic test_dm_random;
        int lat; logic [31:0] rd, exp_rd, a, d; logic err, exp_err, we; logic [3:0] be;
        for (int n = 0; n < 60; n++) begin
            a  = 32'($urandom_range(0, 32'h17F));
            d  = $urandom;
            we = 1'($urandom);
            be = 4'($urandom);
            model_dm(we, be, a, d, exp_rd, exp_err);
            dm_do(we, be, a, d, lat, rd, err);
            checks++;
            if (lat !== DMW + 1 || err !== exp_err || rd !== exp_rd) begin
                errors++; $display("FAIL dm_rand we %0b be %h addr %h lat %0d err %0b rd %h want %0d %0b %h", we, be, a, lat, err, rd, DMW + 1, exp_err, exp_rd);
            end
            $display("dm: we %0b be %h addr %h -> rd %h err %0b", we, be, a, rd, err);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_dm;
        exp_dm  = dm_model[8];
        last_rd = exp_dm;
        IM_REQ = 1'b1; IM_ADDR = 32'h0;
        DM_REQ = 1'b1; DM_WE = 1'b0; DM_BE = 4'h0; DM_ADDR = 32'h20;
        for (int c = 1; c <= 5; c++) begin
            tick;
            if (c == 1) begin DM_REQ = 1'b0; DM_ADDR = 32'h0; end
            checks++;
            if (c <= 4) begin
                if (IM_ACK !== 1'b1 || IM_DATA !== im_model[c-1]) begin
                    errors++; $display("FAIL b2b_im cycle %0d ack %0b data %h want 1 %h", c, IM_ACK, IM_DATA, im_model[c-1]);
                end
                $display("b2b: cycle %0d im -> %h", c, IM_DATA);
            end else if (IM_ACK !== 1'b0) begin
                errors++; $display("FAIL b2b_im_end ack %0b want 0", IM_ACK);
            end
            checks++;
            if (DM_ACK !== (c == 3)) begin
                errors++; $display("FAIL b2b_dm_ack cycle %0d ack %0b want %0b", c, DM_ACK, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (DM_RD_DATA !== exp_dm) begin errors++; $display("FAIL b2b_dm_data rd %h want %h", DM_RD_DATA, exp_dm); end
            end
            if (c < 4) IM_ADDR = 32'(4 * c);
            else IM_REQ = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access;
        int lat; logic [31:0] rd, exp_rd, old; logic err, exp_err;
        old = dm_model[12];
        DM_REQ = 1'b1; DM_WE = 1'b1; DM_BE = 4'hF; DM_ADDR = 32'h30; DM_WR_DATA = ~old;
        tick;
        DM_REQ = 1'b0;
        #2 Z_R = 1'b1;
        #1;
        checks++;
        if (IM_ACK !== 1'b0 || IM_DATA !== 32'h0 || DM_ACK !== 1'b0 || DM_RD_DATA !== 32'h0 || DM_ERR !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs im %0b %h dm %0b %h %0b want all 0", IM_ACK, IM_DATA, DM_ACK, DM_RD_DATA, DM_ERR);
        end
        tick;
        Z_R = 1'b0;
        last_rd = 32'h0;
        for (int c = 0; c < 5; c++) begin
            tick;
            checks++;
            if (DM_ACK !== 1'b0) begin errors++; $display("FAIL midreset_no_ack cycle %0d ack %0b want 0", c, DM_ACK); end
        end
        model_dm(1'b0, 4'h0, 32'h30, 32'h0, exp_rd, exp_err);
        dm_do(1'b0, 4'h0, 32'h30, 32'h0, lat, rd, err);
        checks++;
        if (rd !== old || lat !== 3) begin errors++; $display("FAIL midreset_no_commit rd %h lat %0d want %h 3", rd, lat, old); end
        $display("reset mid-access: read 30 -> %h", rd);
    endtask

    initial begin
        for (int i = 0; i < IM_WORDS; i++) im_model[i] = $urandom;
        im_model[2] = 32'h2008_000A;
        for (int i = 0; i < IM_WORDS; i++) dut.im_mem[i] = im_model[i];
        for (int i = 0; i < DM_WORDS; i++) dm_model[i] = 32'h0;
        last_rd = 32'h0;
        #2;
        test_reset;
        test_im_basic;
        test_dm_preload;
        test_dm_basic;
        test_dm_byte_en;
        test_dm_range;
        test_dm_random;
        test_back_to_back;
        test_reset_mid_access;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
